// File: rtl/decoder_stage_riscv.sv
// rtl/decoder_stage_riscv.sv - registered RV32I decode stage with one-entry output buffer and illegal counter
module decoder_stage_riscv #(
    parameter int ILL_CNT_W     = 16,
    parameter bit STRICT_SYSTEM = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
    input  logic                 flush_i,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [31:0]          pc_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [1:0]           ex_op_a_sel_o,
    output logic [2:0]           ex_op_b_sel_o,
    output logic [4:0]           alu_op_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [2:0]           mem_size_o,
    output logic                 gpr_we_a_o,
    output logic                 wb_src_sel_o,
    output logic                 illegal_instr_o,
    output logic                 branch_o,
    output logic                 jal_o,
    output logic                 jalr_o,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] OP_A_RS1      = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC  = 2'd1;
    localparam logic [1:0] OP_A_ZERO     = 2'd2;

    localparam logic [2:0] OP_B_IMM_I    = 3'd0;
    localparam logic [2:0] OP_B_RS2      = 3'd1;
    localparam logic [2:0] OP_B_IMM_S    = 3'd2;
    localparam logic [2:0] OP_B_IMM_U    = 3'd3;
    localparam logic [2:0] OP_B_INCR     = 3'd4;

    localparam logic [4:0] ALU_ADD       = 5'b00000;
    localparam logic [4:0] ALU_SRA       = 5'b01101;

    localparam logic [2:0] LDST_B        = 3'b000;
    localparam logic       WB_EX_RESULT  = 1'b0;
    localparam logic       WB_LSU_DATA   = 1'b1;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ILL_CNT_W-1:0] CNT_MAX = {ILL_CNT_W{1'b1}};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [1:0] d_op_a;
    logic [2:0] d_op_b;
    logic [4:0] d_alu;
    logic       d_req;
    logic       d_we;
    logic [2:0] d_size;
    logic       d_gpr_we;
    logic       d_wb;
    logic       d_ill;
    logic       d_branch;
    logic       d_jal;
    logic       d_jalr;
    logic       accept;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        d_op_a   = OP_A_RS1;
        d_op_b   = OP_B_IMM_I;
        d_alu    = ALU_ADD;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_size   = LDST_B;
        d_gpr_we = 1'b0;
        d_wb     = WB_EX_RESULT;
        d_ill    = 1'b0;
        d_branch = 1'b0;
        d_jal    = 1'b0;
        d_jalr   = 1'b0;

        unique case (opcode)
            OPC_LOAD: begin
                d_req    = 1'b1;
                d_gpr_we = 1'b1;
                d_wb     = WB_LSU_DATA;
                d_size   = funct3;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    d_ill = 1'b1;
                end
            end
            OPC_STORE: begin
                d_op_b = OP_B_IMM_S;
                d_req  = 1'b1;
                d_we   = 1'b1;
                d_size = funct3;
                if (funct3[2] || funct3 == 3'b011) begin
                    d_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_gpr_we = 1'b1;
                d_alu    = {2'b00, funct3};
                // Only the shift encodings constrain funct7; other immediates span it freely.
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    d_ill = 1'b1;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) begin
                        d_alu = ALU_SRA;
                    end else if (funct7 != 7'b0000000) begin
                        d_ill = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                d_op_b   = OP_B_RS2;
                d_gpr_we = 1'b1;
                d_alu    = {funct7[6:5], funct3};
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    d_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                d_op_a   = OP_A_ZERO;
                d_op_b   = OP_B_IMM_U;
                d_gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                d_op_a   = OP_A_CURR_PC;
                d_op_b   = OP_B_IMM_U;
                d_gpr_we = 1'b1;
            end
            OPC_BRANCH: begin
                d_op_b   = OP_B_RS2;
                d_branch = 1'b1;
                d_alu    = {2'b11, funct3};
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    d_ill = 1'b1;
                end
            end
            OPC_JAL: begin
                d_op_a   = OP_A_CURR_PC;
                d_op_b   = OP_B_INCR;
                d_gpr_we = 1'b1;
                d_jal    = 1'b1;
            end
            OPC_JALR: begin
                d_op_a   = OP_A_CURR_PC;
                d_op_b   = OP_B_INCR;
                d_gpr_we = 1'b1;
                d_jalr   = 1'b1;
                if (funct3 != 3'b000) begin
                    d_ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                if (funct3 != 3'b000) begin
                    d_ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (STRICT_SYSTEM && instr_i != INSTR_ECALL && instr_i != INSTR_EBREAK) begin
                    d_ill = 1'b1;
                end
            end
            default: begin
                d_ill = 1'b1;
            end
        endcase

        if (instr_i[1:0] != 2'b11) begin
            d_ill = 1'b1;
        end

        // Squash: an illegal word must not reach memory, the register file or the PC logic.
        if (d_ill) begin
            d_req    = 1'b0;
            d_we     = 1'b0;
            d_gpr_we = 1'b0;
            d_branch = 1'b0;
            d_jal    = 1'b0;
            d_jalr   = 1'b0;
            d_alu    = ALU_ADD;
            d_size   = LDST_B;
        end
    end

    assign instr_ready_o = !dec_valid_o || dec_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dec_valid_o     <= 1'b0;
            pc_o            <= '0;
            rd_o            <= '0;
            rs1_o           <= '0;
            rs2_o           <= '0;
            ex_op_a_sel_o   <= OP_A_RS1;
            ex_op_b_sel_o   <= '0;
            alu_op_o        <= ALU_ADD;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_size_o      <= LDST_B;
            gpr_we_a_o      <= 1'b0;
            wb_src_sel_o    <= WB_EX_RESULT;
            illegal_instr_o <= 1'b0;
            branch_o        <= 1'b0;
            jal_o           <= 1'b0;
            jalr_o          <= 1'b0;
            ill_cnt_o       <= '0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (accept) begin
            dec_valid_o     <= 1'b1;
            pc_o            <= pc_i;
            rd_o            <= instr_i[11:7];
            rs1_o           <= instr_i[19:15];
            rs2_o           <= instr_i[24:20];
            ex_op_a_sel_o   <= d_op_a;
            ex_op_b_sel_o   <= d_op_b;
            alu_op_o        <= d_alu;
            mem_req_o       <= d_req;
            mem_we_o        <= d_we;
            mem_size_o      <= d_size;
            gpr_we_a_o      <= d_gpr_we;
            wb_src_sel_o    <= d_wb;
            illegal_instr_o <= d_ill;
            branch_o        <= d_branch;
            jal_o           <= d_jal;
            jalr_o          <= d_jalr;
            if (d_ill && ill_cnt_o != CNT_MAX) begin
                ill_cnt_o <= ill_cnt_o + CNT_ONE;
            end
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule
